// File: rtl/iter_shifter_pkg.sv
// Shared encodings for the iterative shift unit.
// Optional rotate: define ITER_SHIFTER_ROTATE_EN.
package iter_shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iter_shifter_if.sv
// Request/result valid-ready bundle for iter_shifter.
// master drives requests and consumes results; slave is the unit.
interface iter_shifter_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] din;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;

  modport master (
    output in_valid, op, shamt, din, out_ready,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  in_valid, op, shamt, din, out_ready,
    output in_ready, out_valid, dout
  );
endinterface

// File: rtl/iter_shifter_shift_step.sv
// One combinational shift step of 0..STEP bits.
// Rotate path exists only with ITER_SHIFTER_ROTATE_EN.
module shift_step
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 2,
  localparam int SHW  = $clog2(WIDTH),
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  op_e              op,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] res
);

`ifdef ITER_SHIFTER_ROTATE_EN
  logic [SHW:0] rk;
  assign rk = (SHW+1)'(WIDTH) - (SHW+1)'(k);
`endif

  always_comb begin
    res = data << k;
    case (op)
      OP_SRL: res = data >> k;
      OP_SRA: res = WIDTH'($signed(data) >>> k);
`ifdef ITER_SHIFTER_ROTATE_EN
      OP_ROL: res = (data << k) | (data >> rk);
`endif
      default: res = data << k;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA shifter, STEP bits per cycle.
// Optional rotate-left on op=11: define ITER_SHIFTER_ROTATE_EN.
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 2,
  localparam int SHW  = $clog2(WIDTH),
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  iter_shifter_if.slave bus,
  output logic          busy
);

  localparam logic [SHW-1:0] STEPV = SHW'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  op_e              op_q, op_d;
  logic [SHW-1:0]   rem_q, rem_d;

  logic [WIDTH-1:0] src;
  op_e              src_op;
  logic [SHW-1:0]   src_rem;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] stepped;
  logic [SHW-1:0]   rem_nx;

  // The first step is taken on the accept edge itself.
  always_comb begin
    if (state_q == ST_IDLE) begin
      src     = bus.din;
      src_op  = op_e'(bus.op);
      src_rem = bus.shamt;
    end else begin
      src     = data_q;
      src_op  = op_q;
      src_rem = rem_q;
    end
    k = (src_rem > STEPV) ? KW'(STEP)
                          : src_rem[KW-1:0];
    rem_nx = src_rem - SHW'(k);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data (src),
    .op   (src_op),
    .k    (k),
    .res  (stepped)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      op_q    <= OP_SLL;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (bus.in_valid) begin
          data_d  = stepped;
          op_d    = src_op;
          rem_d   = rem_nx;
          state_d = (rem_nx == '0) ? ST_DONE
                                   : ST_SHIFT;
        end
      end
      (state_q == ST_SHIFT): begin
        data_d = stepped;
        rem_d  = rem_nx;
        if (rem_nx == '0) state_d = ST_DONE;
      end
      (state_q == ST_DONE): begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.dout      = data_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iter_shifter.sv
// Randomised self-checking bench for iter_shifter.
// Expected results come from a bit-level reference model.
module tb_iter_shifter;

  localparam int WIDTH = 32;
  localparam int STEP  = 2;
  localparam int SHW   = $clog2(WIDTH);

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  iter_shifter_if #(.WIDTH(WIDTH)) bus ();

  iter_shifter #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_shift(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] d,
    input int               s
  );
    logic [WIDTH-1:0] r;
    logic             sign;
    r    = d;
    sign = d[WIDTH-1];
    for (int i = 0; i < s; i++) begin
      case (op)
        2'b01: r = {1'b0, r[WIDTH-1:1]};
        2'b10: r = {sign, r[WIDTH-1:1]};
`ifdef ITER_SHIFTER_ROTATE_EN
        2'b11: r = {r[WIDTH-2:0], r[WIDTH-1]};
`endif
        default: r = {r[WIDTH-2:0], 1'b0};
      endcase
    end
    return r;
  endfunction

  function automatic int ref_lat(input int s);
    int n;
    n = (s + STEP - 1) / STEP;
    return (n < 1) ? 1 : n;
  endfunction

  // Issue one request; hold out_ready low for `hold` cycles in DONE.
  task automatic run_op(
    input string            tag,
    input logic [1:0]       op,
    input logic [WIDTH-1:0] d,
    input int               s,
    input int               hold
  );
    int               lat;
    logic [WIDTH-1:0] exp;
    exp = ref_shift(op, d, s);
    @(negedge clk);
    chk({tag, ":idle_rdy"}, 64'(bus.in_ready), 64'd1);
    bus.op        = op;
    bus.din       = d;
    bus.shamt     = SHW'(s);
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.din      = ~d;
    bus.op       = ~op;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      chk({tag, ":busy"}, 64'(busy), 64'd1);
      chk({tag, ":rdy_lo"}, 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ":lat"}, 64'(lat), 64'(ref_lat(s)));
    chk({tag, ":dout"}, 64'(bus.dout), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ":hold_v"}, 64'(bus.out_valid), 64'd1);
      chk({tag, ":hold_d"}, 64'(bus.dout), 64'(exp));
      chk({tag, ":hold_r"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ":ov_lo"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ":rdy_hi"}, 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] rot_exp;
    int               cyc;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.shamt     = '0;
    bus.din       = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_rdy", 64'(bus.in_ready), 64'd1);
    chk("rst_ov", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dout", 64'(bus.dout), 64'd0);
    rst_n = 1'b1;

    run_op("sll2", 2'b00, 32'h0000_0001, 2, 0);
    chk("sll2_val", 64'(ref_shift(2'b00, 32'h1, 2)),
        64'h4);
    run_op("sra31", 2'b10, 32'h8000_0000, 31, 0);
    chk("sra31_val",
        64'(ref_shift(2'b10, 32'h8000_0000, 31)),
        64'hFFFF_FFFF);
    run_op("srl31", 2'b01, 32'h8000_0000, 31, 1);
    run_op("sll31", 2'b00, 32'h0000_0001, 31, 0);
    run_op("srl0", 2'b01, 32'hF000_000F, 0, 0);
    run_op("srl5", 2'b01, 32'hF000_000F, 5, 0);
    run_op("bp10", 2'b00, 32'h1234_5678, 7, 10);

    // Reset pulse in the middle of a long shift.
    @(negedge clk);
    bus.op       = 2'b01;
    bus.din      = 32'hDEAD_BEEF;
    bus.shamt    = SHW'(20);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_ov", 64'(bus.out_valid), 64'd0);
    chk("mid_rdy", 64'(bus.in_ready), 64'd1);
    chk("mid_busy0", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 2'b00, 32'h0000_0003, 1, 0);

    run_op("op11", 2'b11, 32'h8000_0001, 1, 0);
`ifdef ITER_SHIFTER_ROTATE_EN
    rot_exp = 32'h0000_0003;
`else
    rot_exp = 32'h0000_0002;
`endif
    chk("op11_val", 64'(bus.dout), 64'(rot_exp));

    for (int n = 0; n < 40; n++) begin
      run_op("rnd",
             2'($urandom_range(0, 3)),
             WIDTH'($urandom),
             int'($urandom_range(0, WIDTH - 1)),
             int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
